// File: rtl/avalon_inst_ram.sv
// 64 x 32-bit word memory with an Avalon-MM slave port and a side-band program-load port.
// Define RAM_WAITSTATE_EN to stall each Avalon request for WAIT_STATES cycles.
module avalon_inst_ram #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        RAM_Reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        inst_input,
  input  logic [7:0]  inst_addr,
  input  logic [31:0] instruction
);

  localparam int unsigned WORDS = 64;
  localparam int unsigned DW    = 32;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned LANES = 4;

  logic [WORDS-1:0][DW-1:0] mem;
  logic [IDX_W-1:0]         av_idx;
  logic [IDX_W-1:0]         ld_idx;
  logic                     wr_en;

  assign av_idx = address[7:2];
  assign ld_idx = inst_addr[7:2];

  // Byte offset and the aliased upper address bits carry no meaning here.
  logic unused_addr;
  assign unused_addr = ^{address[31:8], address[1:0], inst_addr[1:0]};

`ifdef RAM_WAITSTATE_EN
  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             done;

  assign req         = read | write;
  assign done        = req && (cnt == CNT_W'(WAIT_STATES));
  assign waitrequest = req && !done;

  // Counts stall cycles of the current request; clears on completion or abort.
  always_ff @(posedge clk or negedge RAM_Reset) begin
    if (!RAM_Reset) begin
      cnt <= '0;
    end else if (!req || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign waitrequest = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^32'(WAIT_STATES);
`endif

  assign wr_en = write & ~waitrequest;

  // Load port is applied last so it overrides an Avalon write to the same word.
  always_ff @(posedge clk or negedge RAM_Reset) begin
    if (!RAM_Reset) begin
      mem <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < int'(LANES); b++) begin
          if (byteenable[b]) begin
            mem[av_idx][8*b +: 8] <= writedata[8*b +: 8];
          end
        end
      end
      if (inst_input) begin
        mem[ld_idx] <= instruction;
      end
    end
  end

  assign readdata = read ? mem[av_idx] : '0;

endmodule

// File: tb/tb_avalon_inst_ram.sv
// Self-checking bench for avalon_inst_ram: directed literals plus randomized traffic
// compared every cycle against a word-array reference model.
module tb_avalon_inst_ram;

  localparam int unsigned WS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        inst_input = 1'b0;
  logic [7:0]  inst_addr = '0;
  logic [31:0] instruction = '0;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [64] = '{default: 32'h0};
  int          age = 0;

  avalon_inst_ram #(.WAIT_STATES(WS)) dut (
    .clk(clk),
    .RAM_Reset(rst_n),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .byteenable(byteenable),
    .waitrequest(waitrequest),
    .readdata(readdata),
    .inst_input(inst_input),
    .inst_addr(inst_addr),
    .instruction(instruction)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Expected stall: a request waits until it has been pending WS cycles.
  function automatic logic exp_wait_f();
`ifdef RAM_WAITSTATE_EN
    return (read || write) && (age < int'(WS));
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: word array updated from the bus rules at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) model[i] = 32'h0;
      age = 0;
    end else begin
      logic acc;
      acc = (read || write) && !exp_wait_f();
      if (write && acc) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) model[address[7:2]][8*b +: 8] = writedata[8*b +: 8];
      end
      if (inst_input) model[inst_addr[7:2]] = instruction;
      if (!(read || write) || acc) age = 0;
      else age = age + 1;
    end
  end

  always @(negedge clk) begin
    logic ew;
    ew = exp_wait_f();
    chk("cmp_waitrequest", {31'b0, waitrequest}, {31'b0, ew});
    if (!ew) chk("cmp_readdata", readdata, read ? model[address[7:2]] : 32'h0);
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_ready_timeout actual=waitrequest_stuck required=ready");
    end
  endtask

  task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    address = a;
    read = 1'b1;
    wait_ready();
    chk(nm, readdata, exp);
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic av_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    address = a;
    writedata = d;
    byteenable = be;
    write = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    inst_addr = a;
    instruction = d;
    inst_input = 1'b1;
    @(posedge clk); #1;
    inst_input = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;

    chk("reset_waitrequest", {31'b0, waitrequest}, 32'h0);
    rd_check(32'hBFC0_0000, 32'h0000_0000, "reset_alias_word0");

    load(8'h04, 32'h2404_FFFF);
    load(8'h08, 32'h2404_0000);
    load(8'h0C, 32'h0064_1024);
    load(8'h10, 32'h0000_0008);
    rd_check(32'hBFC0_000C, 32'h0064_1024, "load_word3_alias");
    rd_check(32'h0000_0010, 32'h0000_0008, "load_word4");
    rd_check(32'h0000_0004, 32'h2404_FFFF, "load_word1");

    av_write(32'h0000_0020, 32'hAABB_CCDD, 4'b1111);
    rd_check(32'h0000_0020, 32'hAABB_CCDD, "write_full");
    av_write(32'h0000_0020, 32'h1122_3344, 4'b0101);
    rd_check(32'h0000_0020, 32'hAA22_CC44, "write_lanes_0101");
    av_write(32'h0000_0020, 32'hFFFF_FFFF, 4'b0000);
    rd_check(32'h0000_0020, 32'hAA22_CC44, "write_be_none");

    // Same-edge collision: load must win on word 0x30.
    @(posedge clk); #1;
    address = 32'h0000_0030;
    writedata = 32'h1234_5678;
    byteenable = 4'b1111;
    write = 1'b1;
    wait_ready();
    inst_addr = 8'h30;
    instruction = 32'hDEAD_BEEF;
    inst_input = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    inst_input = 1'b0;
    rd_check(32'h0000_0030, 32'hDEAD_BEEF, "collision_load_wins");

`ifdef RAM_WAITSTATE_EN
    @(posedge clk); #1;
    address = 32'h0000_0004;
    read = 1'b1;
    @(negedge clk);
    chk("ws_read_cycle1_wait", {31'b0, waitrequest}, 32'h1);
    @(negedge clk);
    chk("ws_read_cycle2_wait", {31'b0, waitrequest}, 32'h0);
    chk("ws_read_cycle2_data", readdata, 32'h2404_FFFF);
    @(posedge clk); #1;
    read = 1'b0;

    @(posedge clk); #1;
    address = 32'h0000_0020;
    writedata = 32'h0000_0000;
    byteenable = 4'b1111;
    write = 1'b1;
    @(negedge clk);
    chk("ws_abort_wait", {31'b0, waitrequest}, 32'h1);
    @(posedge clk); #1;
    write = 1'b0;
    rd_check(32'h0000_0020, 32'hAA22_CC44, "ws_abort_no_write");
`endif

    // Randomized traffic; requests are held while stalled, with occasional aborts.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if ((read || write) && waitrequest) begin
        if ($urandom_range(0, 9) == 0) begin
          read = 1'b0;
          write = 1'b0;
        end
      end else begin
        read = ($urandom_range(0, 1) == 1);
        write = ($urandom_range(0, 2) == 0);
        address = $urandom;
        writedata = $urandom;
        byteenable = 4'($urandom_range(0, 15));
      end
      inst_input = ($urandom_range(0, 3) == 0);
      inst_addr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) inst_addr = address[7:0];
      instruction = $urandom;
    end
    @(posedge clk); #1;
    read = 1'b0;
    write = 1'b0;
    inst_input = 1'b0;

    // Reset in the middle of a write with memory populated.
    @(posedge clk); #1;
    address = 32'h0000_0024;
    writedata = 32'hFFFF_FFFF;
    byteenable = 4'b1111;
    write = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    write = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_waitrequest", {31'b0, waitrequest}, 32'h0);
    for (int i = 0; i < 64; i++) rd_check(32'(i * 4), 32'h0, "post_reset_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_inst_ram.md
# avalon_inst_ram

Word-addressed 256-byte memory with an Avalon-MM slave port and a side-band instruction-load port. It serves as the unified instruction/data memory for the MIPS CPU core in the CPU test harness. The bench pre-loads program words through the load port, then the CPU fetches and accesses data over the Avalon bus.

## Interface
Parameters:
- WAIT_STATES, default 1: number of stall cycles per access; used only when RAM_WAITSTATE_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- RAM_Reset  in  1  reset, asynchronous and active-low; clears all memory and state.
- address  in  32  Avalon byte address. Word index = address[7:2]. Bits [31:8] and [1:0] are ignored, so the full space aliases onto 64 words.
- read  in  1  Avalon read request.
- write  in  1  Avalon write request.
- writedata  in  32  write data.
- byteenable  in  4  byteenable[i] enables lane writedata[8i+7:8i].
- waitrequest  out  1  stall indication; high means the request is not yet accepted.
- readdata  out  32  read data; valid while read=1 and waitrequest=0.
- inst_input  in  1  load-port enable.
- inst_addr  in  8  load byte address; word index = inst_addr[7:2].
- instruction  in  32  word to load.

## Operation
- Storage: 64 x 32-bit words, mem[0..63].
- Reset: RAM_Reset=0 clears every word to 0 asynchronously. It also clears the wait counter, waitrequest=0 and readdata=0. 0x00000000 decodes as a MIPS nop.
- Load port: on a rising edge with inst_input=1, mem[inst_addr[7:2]] <= instruction (full word). The Avalon interface stays live during loading.
- Avalon write: on a rising edge with write=1 and waitrequest=0, each lane i with byteenable[i]=1 is updated from writedata. Disabled lanes keep their value. byteenable=0000 is a legal no-op.
- Avalon read: readdata = mem[address[7:2]] combinationally while read=1. readdata = 0 when read=0.
- Conflicts:
  - read=1 and write=1 in the same cycle: the write is performed; readdata shows the pre-write contents.
  - Load and Avalon write to the same word on the same edge: the load-port word wins entirely.
  - Load and Avalon write to different words: both are performed.
- A read in the cycle after a write to the same word returns the new data.

## Timing
- Without RAM_WAITSTATE_EN: waitrequest is tied to 0. Reads are zero-latency (combinational); writes commit on the rising edge of the request cycle.
- With RAM_WAITSTATE_EN: a stall counter applies to each request, defined as read or write high.
  - On the first cycle of a request, waitrequest=1 for WAIT_STATES cycles, then 0 for one cycle. The access completes in that cycle.
  - The counter reloads after completion, so back-to-back requests each stall.
  - Dropping read/write before completion aborts the request and resets the counter; nothing is written.
  - Master rule: address, writedata and byteenable are held stable while waitrequest=1.
- Reset asserted mid-access: the access is abandoned, the counter clears and memory clears.

## Configuration
- RAM_WAITSTATE_EN
  - Defined: waitrequest is generated by the stall counter, with WAIT_STATES stall cycles per access.
  - Undefined: waitrequest is constant 0, the counter logic is omitted and WAIT_STATES is ignored.

## Test plan
- Reset, then read address 0xBFC00000 -> readdata=0x00000000 (alias of word 0).
- Load 0x2404FFFF @0x04, 0x24040000 @0x08, 0x00641024 @0x0C, 0x00000008 @0x10 via the load port. Then Avalon read 0xBFC0000C -> 0x00641024, and read 0x10 -> 0x00000008.
- Write 0xAABBCCDD with byteenable=1111 to 0x20, then write 0x11223344 with byteenable=0101 -> read 0x20 returns 0xAA22CC44.
- Same-edge collision: load 0xDEADBEEF and Avalon write 0x12345678 (byteenable=1111) to word 0x30 -> read returns 0xDEADBEEF.
- With RAM_WAITSTATE_EN and WAIT_STATES=1: read asserted -> waitrequest=1 for cycle 1 and 0 in cycle 2 with valid data. A write dropped after cycle 1 leaves memory unchanged.
- Assert reset mid-write with memory loaded -> all words read 0 and waitrequest=0 after release.
